// File: rtl/ram_fill_seq.sv
// Streams upstream words into a RAM at consecutive (wrapping) addresses,
// reading each word back the following cycle to flag write corruption.
module ram_fill_seq #(
    parameter int addressWidth = 5,
    parameter int dataWidth    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [addressWidth-1:0] base_addr,
    input  logic [addressWidth:0]   length,
    input  logic                    s_valid,
    input  logic [dataWidth-1:0]    s_data,
    output logic                    s_ready,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [addressWidth-1:0] ram_address,
    output logic [dataWidth-1:0]    ram_din,
    input  logic [dataWidth-1:0]    ram_dout,
    output logic                    busy,
    output logic                    done,
    output logic                    verify_err,
    output logic [addressWidth:0]   word_count
);

    localparam logic [addressWidth:0]   MAX_LEN = {1'b1, {addressWidth{1'b0}}};
    localparam logic [addressWidth:0]   ONE_W   = 1;
    localparam logic [addressWidth-1:0] ONE_A   = 1;

    typedef enum logic [1:0] {IDLE, WRITE, CHECK, DONE} state_t;

    state_t                  state, state_nxt;
    logic [addressWidth-1:0] ptr;
    logic [addressWidth:0]   len_q, len_clamped;
    logic [dataWidth-1:0]    wr_data_q;
    logic                    err_q, chk_pend;
    logic                    start_ok, accept, last_word, mismatch;

    always_comb begin
        len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
        start_ok    = start && (state == IDLE);
        accept      = s_valid && s_ready;
        last_word   = accept && ((word_count + ONE_W) == len_q);
        // chk_pend marks the cycle in which ram_dout reflects the previous write
        mismatch    = chk_pend && (ram_dout != wr_data_q);
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (len_clamped == '0) ? DONE : WRITE;
            WRITE: begin
                s_ready = 1'b1;
                if (last_word) state_nxt = CHECK;
            end
            CHECK: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            len_q      <= '0;
            word_count <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            chk_pend   <= 1'b0;
        end else if (start_ok) begin
            ptr        <= base_addr;
            len_q      <= len_clamped;
            word_count <= '0;
            err_q      <= 1'b0;
            chk_pend   <= 1'b0;
        end else begin
            chk_pend <= accept;
            if (accept) begin
                ptr        <= ptr + ONE_A;
                word_count <= word_count + ONE_W;
                wr_data_q  <= s_data;
            end
            if (mismatch) err_q <= 1'b1;
        end
    end

    assign ram_en      = accept;
    assign ram_we      = accept;
    assign ram_address = ptr;
    assign ram_din     = s_data;
    assign busy        = (state != IDLE);
    assign verify_err  = err_q || mismatch;

endmodule

// File: tb/tb_ram_fill_seq.sv
// Directed bench for ram_fill_seq with a small model RAM that can corrupt one
// address on readback.
module tb_ram_fill_seq;

    logic        clk, rst_n, start, s_valid, s_ready;
    logic [4:0]  base_addr, ram_address;
    logic [5:0]  length, word_count;
    logic [31:0] s_data, ram_din, ram_dout;
    logic        ram_en, ram_we, busy, done, verify_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:31];
    logic [4:0]  last_addr;
    logic        corrupt_q;
    logic        corrupt_en;
    logic [4:0]  corrupt_addr;

    ram_fill_seq #(.addressWidth(5), .dataWidth(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_address(ram_address),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done),
        .verify_err(verify_err), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_address] <= ram_din;
            last_addr        <= ram_address;
            corrupt_q        <= corrupt_en && (ram_address == corrupt_addr);
        end
    end
    assign ram_dout = mem[last_addr] ^ (corrupt_q ? 32'h1 : 32'h0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] b, input logic [5:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        base_addr = '0; length = '0; corrupt_en = 1'b0; corrupt_addr = '0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({busy, done, s_ready, ram_en, ram_we, verify_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy, done, s_ready, ram_en, ram_we, verify_err});
        end
        checks++;
        if (word_count !== 6'd0) begin
            failures++;
            $display("FAIL reset_wc got=%0d exp=0", word_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] d [4];
        d = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        s_valid = 1'b1;
        s_data  = d[0];
        do_start(5'd0, 6'd4);
        for (int i = 0; i < 4; i++) begin
            s_data = d[i];
            @(negedge clk);
            checks++;
            if (ram_we !== 1'b1 || ram_en !== 1'b1 || ram_address !== 5'(i) || ram_din !== d[i]) begin
                failures++;
                $display("FAIL basic_wr%0d we=%b en=%b addr=%0d din=%h exp addr=%0d din=%h",
                         i, ram_we, ram_en, ram_address, ram_din, i, d[i]);
            end
            tick();
        end
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || ram_en !== 1'b0) begin
            failures++;
            $display("FAIL basic_check busy=%b done=%b en=%b exp 1 0 0", busy, done, ram_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got=%b exp=1", done);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || word_count !== 6'd4 || verify_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_end done=%b busy=%b wc=%0d verr=%b exp 0 0 4 0",
                     done, busy, word_count, verify_err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[i] !== d[i]) begin
                failures++;
                $display("FAIL basic_mem%0d got=%h exp=%h", i, mem[i], d[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] ea;
        s_valid = 1'b1;
        do_start(5'd30, 6'd4);
        for (int i = 0; i < 4; i++) begin
            ea     = 5'(30 + i);
            s_data = 32'h5000_0000 + 32'(i);
            @(negedge clk);
            checks++;
            if (ram_we !== 1'b1 || ram_address !== ea) begin
                failures++;
                $display("FAIL wrap_wr%0d we=%b addr=%0d exp addr=%0d", i, ram_we, ram_address, ea);
            end
            tick();
        end
        s_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || word_count !== 6'd4) begin
            failures++;
            $display("FAIL wrap_end busy=%b wc=%0d exp 0 4", busy, word_count);
        end
    endtask

    task automatic test_stall();
        logic       pat [4];
        logic [4:0] ea  [3];
        logic [5:0] ewc [4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0};
        ea  = '{5'd10, 5'd11, 5'd11};
        ewc = '{6'd0, 6'd1, 6'd1, 6'd2};
        s_valid = 1'b0;
        do_start(5'd10, 6'd2);
        for (int i = 0; i < 4; i++) begin
            s_valid = pat[i];
            s_data  = 32'h7700_0000 + 32'(i);
            @(negedge clk);
            checks++;
            if (ram_we !== pat[i] || ram_en !== pat[i] || word_count !== ewc[i]) begin
                failures++;
                $display("FAIL stall_c%0d we=%b en=%b wc=%0d exp we=%b wc=%0d",
                         i, ram_we, ram_en, word_count, pat[i], ewc[i]);
            end
            if (i < 3) begin
                checks++;
                if (ram_address !== ea[i]) begin
                    failures++;
                    $display("FAIL stall_addr%0d got=%0d exp=%0d", i, ram_address, ea[i]);
                end
            end
            tick();
        end
        s_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || word_count !== 6'd2) begin
            failures++;
            $display("FAIL stall_end busy=%b wc=%0d exp 0 2", busy, word_count);
        end
    endtask

    task automatic test_verify();
        corrupt_en   = 1'b1;
        corrupt_addr = 5'd1;
        s_valid      = 1'b1;
        do_start(5'd0, 6'd3);
        for (int i = 0; i < 4; i++) begin
            s_data  = 32'h0000_0100 + 32'(i);
            s_valid = (i < 3);
            @(negedge clk);
            checks++;
            if (verify_err !== (i >= 2)) begin
                failures++;
                $display("FAIL verify_c%0d got=%b exp=%b", i, verify_err, (i >= 2));
            end
            tick();
        end
        s_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || verify_err !== 1'b1 || word_count !== 6'd3) begin
            failures++;
            $display("FAIL verify_end busy=%b verr=%b wc=%0d exp 0 1 3", busy, verify_err, word_count);
        end
        corrupt_en = 1'b0;
    endtask

    task automatic test_zero_len();
        s_valid = 1'b1;
        do_start(5'd7, 6'd0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || ram_en !== 1'b0 || word_count !== 6'd0 || verify_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_done done=%b en=%b wc=%0d verr=%b exp 1 0 0 0",
                     done, ram_en, word_count, verify_err);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ram_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle done=%b busy=%b en=%b exp 0 0 0", done, busy, ram_en);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_busy_ignore();
        s_valid = 1'b0;
        do_start(5'd20, 6'd2);
        do_start(5'd3, 6'd5);
        s_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data = 32'h2000_0000 + 32'(i);
            @(negedge clk);
            checks++;
            if (ram_we !== 1'b1 || ram_address !== 5'(20 + i)) begin
                failures++;
                $display("FAIL busy_wr%0d we=%b addr=%0d exp addr=%0d", i, ram_we, ram_address, 20 + i);
            end
            tick();
        end
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (word_count !== 6'd2 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL busy_check wc=%0d busy=%b done=%b exp 2 1 0", word_count, busy, done);
        end
        repeat (2) tick();
    endtask

    task automatic test_clamp();
        int n_wr;
        int bad_addr;
        n_wr     = 0;
        bad_addr = 0;
        s_valid  = 1'b1;
        do_start(5'd0, 6'd40);
        for (int i = 0; i < 33; i++) begin
            s_data = 32'hC000_0000 + 32'(i);
            @(negedge clk);
            if (ram_we) begin
                n_wr++;
                if (ram_address !== 5'(i)) bad_addr++;
            end
            tick();
        end
        s_valid = 1'b0;
        checks++;
        if (n_wr != 32 || bad_addr != 0) begin
            failures++;
            $display("FAIL clamp_writes got=%0d bad_addr=%0d exp 32 0", n_wr, bad_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || word_count !== 6'd32) begin
            failures++;
            $display("FAIL clamp_end busy=%b wc=%0d exp 0 32", busy, word_count);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray   = 0;
        s_valid = 1'b1;
        s_data  = 32'h8888_0000;
        do_start(5'd0, 6'd8);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, s_ready, ram_en, ram_we, verify_err} !== 6'b0 || word_count !== 6'd0) begin
            failures++;
            $display("FAIL rstmid_async flags=%b wc=%0d exp 000000 0",
                     {busy, done, s_ready, ram_en, ram_we, verify_err}, word_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            if (ram_en || ram_we) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rstmid_stray got=%0d exp=0", stray);
        end
        tick();
        s_data = 32'h5555_0005;
        do_start(5'd5, 6'd1);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_address !== 5'd5) begin
            failures++;
            $display("FAIL rstmid_restart we=%b addr=%0d exp 1 5", ram_we, ram_address);
        end
        tick();
        s_valid = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_verify();
        test_zero_len();
        test_busy_ignore();
        test_clamp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_fill_seq.md
RAM_FILL_SEQ -- requirements
Module: ram_fill_seq

Interface
REQ-001 SHALL have parameter addressWidth, default 5, RAM address width.
REQ-002 SHALL have parameter dataWidth, default 32, RAM data width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a fill; honoured only in IDLE.
REQ-006 SHALL have port base_addr, input, addressWidth, first RAM address; sampled when start is accepted.
REQ-007 SHALL have port length, input, addressWidth+1, number of words to write; sampled when start is accepted.
REQ-008 SHALL have port s_valid, input, 1, upstream data word valid.
REQ-009 SHALL have port s_data, input, dataWidth, upstream data word.
REQ-010 SHALL have port s_ready, output, 1, block accepts s_data this cycle.
REQ-011 SHALL have port ram_en, output, 1, RAM enable.
REQ-012 SHALL have port ram_we, output, 1, RAM write enable.
REQ-013 SHALL have port ram_address, output, addressWidth, RAM address.
REQ-014 SHALL have port ram_din, output, dataWidth, RAM write data.
REQ-015 SHALL have port ram_dout, input, dataWidth, RAM data at last-written address, valid the cycle after a write.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at fill completion.
REQ-018 SHALL have port verify_err, output, 1, sticky readback-mismatch flag.
REQ-019 SHALL have port word_count, output, addressWidth+1, words written in the current or last fill.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, CHECK, DONE.
REQ-021 IDLE -> WRITE on start with length != 0: latch base_addr into the address pointer, latch length, clear word_count and verify_err.
REQ-022 start with length == 0 in IDLE SHALL go directly to DONE: no RAM access, word_count = 0.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 In WRITE, s_ready = 1; all other states s_ready = 0.
REQ-025 ram_en = ram_we = s_valid & s_ready, combinational; ram_address = pointer; ram_din = s_data; no write in any other state.
REQ-026 Each accepted word SHALL increment the pointer modulo 2^addressWidth (wrap from all-ones to 0) and increment word_count.
REQ-027 The cycle after each write, ram_dout SHALL be compared to the registered written word; on mismatch verify_err sets and holds until the next accepted start or reset.
REQ-028 Comparison for write N SHALL occur in the cycle of write N+1 or a stall cycle, giving back-to-back throughput of one word per clock.
REQ-029 When the last word (word_count reaches length) is accepted, WRITE -> CHECK; CHECK performs the final comparison, then -> DONE.
REQ-030 DONE SHALL assert done for exactly one cycle, then -> IDLE.
REQ-031 s_valid low in WRITE SHALL stall with no RAM access; pointer and count hold.
REQ-032 length > 2^addressWidth SHALL be clamped to 2^addressWidth.
REQ-033 word_count and verify_err SHALL hold their final values in IDLE until the next accepted start.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, pointer 0, word_count 0, verify_err 0, done 0, busy 0, s_ready 0, ram_en 0, ram_we 0, including mid-fill.
REQ-035 After rst_n deasserts, no RAM access SHALL occur until a new start.

Verification
REQ-036 base_addr=0, length=4, s_valid held high, data A,B,C,D, ram_dout from a model RAM -> writes at addresses 0..3 on 4 consecutive clocks, done pulses 2 cycles after last write, word_count=4, verify_err=0.
REQ-037 base_addr=30, length=4 (addressWidth=5) -> writes at addresses 30,31,0,1.
REQ-038 s_valid toggled 1,0,1,0 -> ram_we follows accepted words only, pointer holds during gaps, word_count correct.
REQ-039 Model RAM corrupts the second word on readback -> verify_err rises the cycle after that write and remains 1 after done.
REQ-040 start with length=0 -> done pulses next cycle, no ram_en, word_count=0; start while busy -> ignored.
REQ-041 rst_n asserted after 2 of 8 writes -> all outputs at reset values asynchronously, no further writes, next start with base_addr=5 writes at address 5 first.
